// File: rtl/vedic_multiplier_pipe.sv
// Pipelined Urdhva-Tiryagbhyam multiplier: an array of 2x2 Vedic cells feeds one
// merge register per recursion level; signed operands are handled as sign-magnitude.
module vedic_multiplier_pipe #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 busy
);
  localparam int LAT = $clog2(WIDTH);

  function automatic logic [3:0] vedic2x2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] mid, top;
    mid = {1'b0, a[1] & b[0]} + {1'b0, a[0] & b[1]};
    top = {1'b0, a[1] & b[1]} + {1'b0, mid[1]};
    return {top, mid[0], a[0] & b[0]};
  endfunction

  logic             adv;
  logic [LAT:1]     vld_pipe_q;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             sgn_d;

  // Global stall: every stage moves only when the output slot is free or draining.
  assign adv       = !vld_pipe_q[LAT] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe_q[LAT];
  assign busy      = |vld_pipe_q;

  // Unary minus of the most-negative value wraps to 2^(W-1), which is the correct magnitude.
  always_comb begin
    mag_a = in_a;
    mag_b = in_b;
    sgn_d = 1'b0;
    if (in_signed) begin
      if (in_a[WIDTH-1]) mag_a = -in_a;
      if (in_b[WIDTH-1]) mag_b = -in_b;
      sgn_d = in_a[WIDTH-1] ^ in_b[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
    end else if (adv) begin
      vld_pipe_q[1] <= in_valid;
      for (int k = 2; k <= LAT; k++) vld_pipe_q[k] <= vld_pipe_q[k-1];
    end
  end

  // Level j holds (WIDTH/2^j)^2 products of 2^j-bit chunks, index = a_chunk*N + b_chunk.
  for (genvar j = 1; j <= LAT; j++) begin : g_lvl
    localparam int N  = WIDTH >> j;
    localparam int PW = 2 << j;
    logic [N*N-1:0][PW-1:0] mag, pp_d, pp_q;
    logic                   sgn_in;

    if (j == 1) begin : g_cell
      assign sgn_in = sgn_d;
      always_comb begin
        mag = '0;
        for (int ia = 0; ia < N; ia++)
          for (int ib = 0; ib < N; ib++)
            mag[ia*N+ib] = vedic2x2(mag_a[2*ia +: 2], mag_b[2*ib +: 2]);
      end
    end else begin : g_merge
      assign sgn_in = g_lvl[j-1].g_sgn.sgn_q;
      // {hh,ll} concatenation is exact since ll < 2^(PW/2); cross terms added at full width.
      always_comb begin
        mag = '0;
        for (int ia = 0; ia < N; ia++)
          for (int ib = 0; ib < N; ib++)
            mag[ia*N+ib] = {g_lvl[j-1].pp_q[(2*ia+1)*(2*N) + 2*ib+1],
                            g_lvl[j-1].pp_q[(2*ia)*(2*N) + 2*ib]}
                         + ((PW'(g_lvl[j-1].pp_q[(2*ia+1)*(2*N) + 2*ib])
                           + PW'(g_lvl[j-1].pp_q[(2*ia)*(2*N) + 2*ib+1])) << (PW/4));
      end
    end

    if (j == LAT) begin : g_neg
      assign pp_d[0] = sgn_in ? -mag[0] : mag[0];
    end else begin : g_sgn
      logic sgn_q;
      assign pp_d = mag;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      sgn_q <= 1'b0;
        else if (adv) sgn_q <= sgn_in;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)      pp_q <= '0;
      else if (adv) pp_q <= pp_d;
    end
  end

  assign out_product = g_lvl[LAT].pp_q[0];

endmodule

// File: tb/tb_vedic_multiplier_pipe.sv
// Randomized bench for vedic_multiplier_pipe: WIDTH=8 main instance plus a
// WIDTH=2/4/16/32 sweep, all checked against a plain-arithmetic product model.
module tb_vedic_multiplier_pipe;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             in_valid, in_signed, out_ready;
  logic [W-1:0]     in_a, in_b;
  logic             in_ready, out_valid, busy;
  logic [2*W-1:0]   out_product;
  int checks = 0;
  int errors = 0;

  vedic_multiplier_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .out_valid(out_valid),
    .out_ready(out_ready), .out_product(out_product), .busy(busy));

  logic [31:0] sw_a, sw_b;
  logic        sw_valid, sw_signed;
  wire  [3:0]  sw_ov, sw_ir, sw_busy;
  wire  [3:0]  p2;
  wire  [7:0]  p4;
  wire  [31:0] p16;
  wire  [63:0] p32;

  vedic_multiplier_pipe #(.WIDTH(2)) dut_w2 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[0]),
    .in_a(sw_a[1:0]), .in_b(sw_b[1:0]), .in_signed(sw_signed), .out_valid(sw_ov[0]),
    .out_ready(1'b1), .out_product(p2), .busy(sw_busy[0]));
  vedic_multiplier_pipe #(.WIDTH(4)) dut_w4 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[1]),
    .in_a(sw_a[3:0]), .in_b(sw_b[3:0]), .in_signed(sw_signed), .out_valid(sw_ov[1]),
    .out_ready(1'b1), .out_product(p4), .busy(sw_busy[1]));
  vedic_multiplier_pipe #(.WIDTH(16)) dut_w16 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[2]),
    .in_a(sw_a[15:0]), .in_b(sw_b[15:0]), .in_signed(sw_signed), .out_valid(sw_ov[2]),
    .out_ready(1'b1), .out_product(p16), .busy(sw_busy[2]));
  vedic_multiplier_pipe #(.WIDTH(32)) dut_w32 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[3]),
    .in_a(sw_a), .in_b(sw_b), .in_signed(sw_signed), .out_valid(sw_ov[3]),
    .out_ready(1'b1), .out_product(p32), .busy(sw_busy[3]));

  // Reference: interpret operands at width w, multiply as integers, keep 2w bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input bit s, input int w);
    logic [63:0] m;
    longint ai, bi, p;
    m  = (w >= 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    ai = longint'(a & m[31:0]);
    bi = longint'(b & m[31:0]);
    if (s && ai[w-1]) ai = ai - (longint'(1) << w);
    if (s && bi[w-1]) bi = bi - (longint'(1) << w);
    p = ai * bi;
    if (2 * w >= 64) return p;
    return p & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (out_product !== 16'h0) begin errors++; $display("FAIL reset_product: got %h want 0000", out_product); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (sw_busy !== 4'h0 || sw_ov !== 4'h0) begin errors++; $display("FAIL reset_sweep: busy %b valid %b want 0", sw_busy, sw_ov); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    logic want;
    out_ready = 1'b1;
    in_a = 8'hFF; in_b = 8'hFF; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      want = (c == 3);
      checks++;
      if (out_valid !== want) begin errors++; $display("FAIL latency_valid cycle %0d: got %b want %b", c, out_valid, want); end
      if (c < 3) begin @(posedge clk); #1; end
    end
    checks++; if (out_product !== 16'hFE01) begin errors++; $display("FAIL latency_product: got %h want fe01", out_product); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL latency_drain: valid %b busy %b want 0 0", out_valid, busy); end
  endtask

  task automatic test_corners();
    logic [7:0]  ca[4] = '{8'h80, 8'hFF, 8'h80, 8'h80};
    logic [7:0]  cb[4] = '{8'h80, 8'h7F, 8'h7F, 8'h7F};
    bit          cs[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] ce[4] = '{16'h4000, 16'hFF81, 16'hC080, 16'h3F80};
    out_ready = 1'b1;
    for (int t = 0; t < 7; t++) begin
      in_valid = (t < 4);
      if (t < 4) begin in_a = ca[t]; in_b = cb[t]; in_signed = cs[t]; end
      @(posedge clk); #1;
      if (t >= 2 && t < 6) begin
        checks++;
        if (out_valid !== 1'b1 || out_product !== ce[t-2])
          begin errors++; $display("FAIL corner_%0d: valid %b product %h want 1 %h", t-2, out_valid, out_product, ce[t-2]); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  qa[$], qb[$];
    bit          qs[$];
    logic [31:0] r;
    logic [63:0] e;
    int          idx;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      r = $urandom();
      qa.push_back(r[7:0]); qb.push_back(r[15:8]); qs.push_back(r[16]);
    end
    for (int t = 0; t < 67; t++) begin
      in_valid = (t < 64);
      if (t < 64) begin in_a = qa[t]; in_b = qb[t]; in_signed = qs[t]; end
      #1;
      if (t < 64) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready %0d: got %b want 1", t, in_ready); end
      end
      @(posedge clk); #1;
      idx = t - 2;
      if (idx >= 0 && idx < 64) begin
        e = ref_mul({24'd0, qa[idx]}, {24'd0, qb[idx]}, qs[idx], 8);
        checks++;
        if (out_valid !== 1'b1 || out_product !== e[15:0])
          begin errors++; $display("FAIL b2b_%0d: valid %b product %h want 1 %h", idx, out_valid, out_product, e[15:0]); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0]  pa, pb;
    bit          ps;
    logic [31:0] r;
    logic [63:0] e;
    logic [15:0] expq[$];
    logic [15:0] held, want;
    int sent = 0, got = 0, stall_left = -1, cyc = 0;
    held = '0;
    r = $urandom(); pa = r[7:0]; pb = r[15:8]; ps = r[16];
    while (got < 10 && cyc < 100) begin
      if (stall_left < 0 && out_valid) begin stall_left = 5; held = out_product; end
      out_ready = !(stall_left > 0);
      in_valid = (sent < 10); in_a = pa; in_b = pb; in_signed = ps;
      #1;
      if (stall_left > 0) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_product !== held)
          begin errors++; $display("FAIL bp_stall: in_ready %b valid %b product %h want 0 1 %h", in_ready, out_valid, out_product, held); end
      end
      if (in_valid && in_ready) begin
        e = ref_mul({24'd0, pa}, {24'd0, pb}, ps, 8);
        expq.push_back(e[15:0]);
        sent++;
        r = $urandom(); pa = r[7:0]; pb = r[15:8]; ps = r[16];
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL bp_extra: got product %h want none", out_product);
        end else begin
          want = expq.pop_front();
          if (out_product !== want) begin errors++; $display("FAIL bp_product_%0d: got %h want %h", got, out_product, want); end
        end
        got++;
      end
      if (stall_left > 0) stall_left--;
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (got != 10 || sent != 10) begin errors++; $display("FAIL bp_count: sent %0d got %0d want 10 10", sent, got); end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_tail: valid %b busy %b want 0 0", out_valid, busy); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r = $urandom(); in_a = r[7:0]; in_b = r[15:8]; in_signed = r[16];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (out_product !== 16'h0) begin errors++; $display("FAIL midrst_product: got %h want 0000", out_product); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale cycle %0d: got %b want 0", c, out_valid); end
    end
  endtask

  task automatic test_sweep();
    logic [31:0] qa[$], qb[$];
    bit          qs[$];
    int          wd[4] = '{2, 4, 16, 32};
    logic [31:0] r, c[4];
    logic [63:0] got, e;
    int          n, idx, lat;
    for (int i = 0; i < 512; i++) begin
      r = $urandom(); qa.push_back({r[31:4], i[3:0]});
      r = $urandom(); qb.push_back({r[31:4], i[7:4]});
      qs.push_back(i[8]);
    end
    for (int k = 0; k < 4; k++) begin
      c[0] = 32'd0; c[1] = 32'd1; c[2] = 32'hFFFF_FFFF; c[3] = 32'd1 << (wd[k] - 1);
      for (int x = 0; x < 4; x++)
        for (int y = 0; y < 4; y++)
          for (int s = 0; s < 2; s++) begin
            qa.push_back(c[x]); qb.push_back(c[y]); qs.push_back(s[0]);
          end
    end
    for (int i = 0; i < 200; i++) begin
      r = $urandom(); qa.push_back(r);
      r = $urandom(); qb.push_back(r);
      r = $urandom(); qs.push_back(r[0]);
    end
    n = qa.size();
    for (int t = 0; t < n + 6; t++) begin
      sw_valid = (t < n);
      if (t < n) begin sw_a = qa[t]; sw_b = qb[t]; sw_signed = qs[t]; end
      @(posedge clk); #1;
      checks++; if (sw_ir !== 4'hF) begin errors++; $display("FAIL sweep_in_ready: got %b want 1111", sw_ir); end
      for (int k = 0; k < 4; k++) begin
        lat = $clog2(wd[k]);
        idx = t - lat + 1;
        checks++;
        if (sw_ov[k] !== (idx >= 0 && idx < n)) begin
          errors++; $display("FAIL sweep_w%0d_valid t=%0d: got %b want %b", wd[k], t, sw_ov[k], (idx >= 0 && idx < n));
        end else if (idx >= 0 && idx < n) begin
          case (k)
            0:       got = 64'(p2);
            1:       got = 64'(p4);
            2:       got = 64'(p16);
            default: got = p32;
          endcase
          e = ref_mul(qa[idx], qb[idx], qs[idx], wd[k]);
          checks++;
          if (got !== e) begin errors++; $display("FAIL sweep_w%0d_product %0d: got %h want %h", wd[k], idx, got, e); end
        end
      end
    end
    sw_valid = 1'b0;
    checks++; if (sw_busy !== 4'h0) begin errors++; $display("FAIL sweep_drain: busy %b want 0000", sw_busy); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_signed = 1'b0;
    test_reset();
    test_latency();
    test_corners();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
